// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CR16-style sequencer.
//   - FSM state encodings (legacy-compatible localparams)
//   - opcode / extension / condition-code constants
//   - flag bit indices into the {C,L,F,Z,N} flag vector
//   - instruction class type and decode helpers
package cpu_ctrl_pkg;

  // FSM states
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  // Primary opcodes IR[15:12]
  localparam logic [3:0] OP_RR    = 4'b0000;  // register-register ALU, op in ext field
  localparam logic [3:0] OP_EXT   = 4'b0100;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  // Extension field IR[7:4]
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_CMP   = 4'b1011;  // CMP in the register-register form

  // Condition codes IR[11:8]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Flag bit positions in flags[4:0] = {C,L,F,Z,N}
  localparam int unsigned FLAG_C = 4;
  localparam int unsigned FLAG_L = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLoad,
    ClsStor,
    ClsJcond,
    ClsBcond,
    ClsNop
  } instr_cls_e;

  function automatic instr_cls_e decode_cls(input logic [3:0] op, input logic [3:0] ext,
                                            input logic is_zero);
    instr_cls_e cls;
    if (is_zero) begin
      cls = ClsNop;
    end else if (op == OP_BCOND) begin
      cls = ClsBcond;
    end else if (op == OP_EXT) begin
      case (ext)
        EXT_LOAD:  cls = ClsLoad;
        EXT_STOR:  cls = ClsStor;
        EXT_JCOND: cls = ClsJcond;
        default:   cls = ClsNop;  // undefined extensions retire as NOP
      endcase
    end else begin
      cls = ClsAlu;
    end
    return cls;
  endfunction

  // CMP only updates flags; both immediate and register forms count.
  function automatic logic is_cmp(input logic [3:0] op, input logic [3:0] ext);
    return (op == OP_CMPI) || ((op == OP_RR) && (ext == EXT_CMP));
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_cond_eval.sv
// Branch/jump condition evaluator, shared by Bcond and Jcond.
// Ports:
//   cond_i   condition code IR[11:8]
//   flags_i  {C,L,F,Z,N}
//   taken_o  1 when the condition holds
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [4:0] flags_i,
  output logic       taken_o
);

  logic c, l, f, z, n;

  assign c = flags_i[FLAG_C];
  assign l = flags_i[FLAG_L];
  assign f = flags_i[FLAG_F];
  assign z = flags_i[FLAG_Z];
  assign n = flags_i[FLAG_N];

  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_CS: taken_o = c;
      COND_CC: taken_o = !c;
      COND_HI: taken_o = l;
      COND_LS: taken_o = !l;
      COND_GT: taken_o = n;
      COND_LE: taken_o = !n;
      COND_FS: taken_o = f;
      COND_FC: taken_o = !f;
      COND_LO: taken_o = !l && !z;
      COND_HS: taken_o = l || z;
      COND_LT: taken_o = !n && !z;
      COND_GE: taken_o = n || z;
      COND_UC: taken_o = 1'b1;
      COND_NV: taken_o = 1'b0;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit CR16-style core.
// Owns every PC decision (increment, branch, jump) and stalls on mem_ready.
// Optional feature macro: CPU_CTRL_HALT_EN (16'h0000 becomes HALT; otherwise NOP).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   instr_i          instruction word from memory (valid in fetch with mem_ready_i)
//   flags_i          {C,L,F,Z,N}
//   mem_ready_i      memory access completes this cycle
//   ir_load_o        latch instr into IR
//   pc_en_o          PC update strobe; pc_branch_o / pc_jump_o select the source
//   pc_disp_o        IR[7:0] branch displacement (sign-extended by the datapath)
//   rf_we_o          register file write; rf_src_mem_o selects memory write-back
//   flags_we_o       flag register write
//   mem_addr_sel_o   0 = PC, 1 = Raddr drives the memory address
//   mem_req_o        memory request; mem_we_o write strobe
//   halted_o         halt indication (tied 0 without CPU_CTRL_HALT_EN)
module cpu_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DISP_W       = 8,
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr_i,
  input  logic [4:0]        flags_i,
  input  logic              mem_ready_i,
  output logic              ir_load_o,
  output logic              pc_en_o,
  output logic              pc_branch_o,
  output logic [DISP_W-1:0] pc_disp_o,
  output logic              pc_jump_o,
  output logic              rf_we_o,
  output logic              rf_src_mem_o,
  output logic              flags_we_o,
  output logic              mem_addr_sel_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic              halted_o
);

  // MEM_WAIT_MAX is informational; memory waits on mem_ready are unbounded.
  if (MEM_WAIT_MAX != 0) begin : g_wait_bound_unused
  end

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [3:0]  ir_op, ir_ext, ir_cond;
  instr_cls_e  cls;
  logic        cmp;
  logic        taken;

  logic ir_load, pc_en, pc_branch, pc_jump, rf_we, rf_src_mem, flags_we;
  logic mem_addr_sel, mem_req, mem_we, halted;

  assign ir_op   = ir_q[15:12];
  assign ir_cond = ir_q[11:8];
  assign ir_ext  = ir_q[7:4];
  assign cls     = decode_cls(ir_op, ir_ext, ir_q == 16'h0000);
  assign cmp     = is_cmp(ir_op, ir_ext);

  cond_eval u_cond_eval (
    .cond_i  (ir_cond),
    .flags_i (flags_i),
    .taken_o (taken)
  );

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    pc_branch    = 1'b0;
    pc_jump      = 1'b0;
    rf_we        = 1'b0;
    rf_src_mem   = 1'b0;
    flags_we     = 1'b0;
    mem_addr_sel = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    halted       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready_i) begin
          ir_load = 1'b1;
          ir_d    = instr_i;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = ((cls == ClsLoad) || (cls == ClsStor)) ? S_MEM : S_EXEC;
      end

      S_EXEC: begin
        pc_en   = 1'b1;
        state_d = S_FETCH;
        case (cls)
          ClsAlu: begin
            flags_we = 1'b1;
            rf_we    = !cmp;
          end
          ClsBcond: pc_branch = taken;
          ClsJcond: pc_jump   = taken;
`ifdef CPU_CTRL_HALT_EN
          ClsNop: begin
            // Only the all-zero word halts; undefined extensions still retire as NOP.
            if (ir_q == 16'h0000) begin
              pc_en   = 1'b0;
              state_d = S_HALT;
            end
          end
`endif
          default: ;
        endcase
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == ClsStor);
        if (mem_ready_i) begin
          pc_en      = 1'b1;
          rf_we      = (cls == ClsLoad);
          rf_src_mem = (cls == ClsLoad);
          state_d    = S_FETCH;
        end
      end

`ifdef CPU_CTRL_HALT_EN
      S_HALT: begin
        halted = 1'b1;
      end
`endif

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Reset is synchronous, so the state register still holds its old value during the
  // reset cycle; gate every output so nothing (especially a write strobe) escapes.
  assign ir_load_o      = ir_load      & ~rst;
  assign pc_en_o        = pc_en        & ~rst;
  assign pc_branch_o    = pc_branch    & ~rst;
  assign pc_jump_o      = pc_jump      & ~rst;
  assign rf_we_o        = rf_we        & ~rst;
  assign rf_src_mem_o   = rf_src_mem   & ~rst;
  assign flags_we_o     = flags_we     & ~rst;
  assign mem_addr_sel_o = mem_addr_sel & ~rst;
  assign mem_req_o      = mem_req      & ~rst;
  assign mem_we_o       = mem_we       & ~rst;
  assign halted_o       = halted       & ~rst;
  assign pc_disp_o      = rst ? '0 : ir_q[DISP_W-1:0];

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed self-checking bench for cpu_seq_ctrl.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_cpu_seq_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic [4:0]  flags;
  logic        mem_ready;
  logic        ir_load, pc_en, pc_branch, pc_jump, rf_we, rf_src_mem, flags_we;
  logic        mem_addr_sel, mem_req, mem_we, halted;
  logic [7:0]  pc_disp;

  int total;
  int bad;

  // Packed output bit positions
  localparam logic [10:0] IRL  = 11'b100_0000_0000;
  localparam logic [10:0] PCEN = 11'b010_0000_0000;
  localparam logic [10:0] BR   = 11'b001_0000_0000;
  localparam logic [10:0] JMP  = 11'b000_1000_0000;
  localparam logic [10:0] RFWE = 11'b000_0100_0000;
  localparam logic [10:0] RSRC = 11'b000_0010_0000;
  localparam logic [10:0] FWE  = 11'b000_0001_0000;
  localparam logic [10:0] ASEL = 11'b000_0000_1000;
  localparam logic [10:0] MREQ = 11'b000_0000_0100;
  localparam logic [10:0] MWE  = 11'b000_0000_0010;
  localparam logic [10:0] HALT = 11'b000_0000_0001;

  typedef struct packed {
    logic [15:0] ins;
    logic [4:0]  fl;
    logic [10:0] ex;
    logic [7:0]  disp;
  } vec_t;

  cpu_seq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .instr_i        (instr),
    .flags_i        (flags),
    .mem_ready_i    (mem_ready),
    .ir_load_o      (ir_load),
    .pc_en_o        (pc_en),
    .pc_branch_o    (pc_branch),
    .pc_disp_o      (pc_disp),
    .pc_jump_o      (pc_jump),
    .rf_we_o        (rf_we),
    .rf_src_mem_o   (rf_src_mem),
    .flags_we_o     (flags_we),
    .mem_addr_sel_o (mem_addr_sel),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .halted_o       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {ir_load, pc_en, pc_branch, pc_jump, rf_we, rf_src_mem, flags_we,
            mem_addr_sel, mem_req, mem_we, halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; instr = 16'h0512; flags = 5'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (outs() !== 11'b0 || pc_disp !== 8'h00) begin
        bad++;
        $display("FAIL reset_outs[%0d] got=%b/%h want=%b/00", i, outs(), pc_disp, 11'b0);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (outs() !== (IRL | MREQ)) begin
      bad++;
      $display("FAIL reset_first_fetch got=%b want=%b", outs(), IRL | MREQ);
    end
  endtask

  // Entry: start of a fetch cycle. Exit: start of the following fetch cycle.
  task automatic test_alu();
    instr = 16'h0512; mem_ready = 1'b1;
    #1;
    total++;
    if (outs() !== (IRL | MREQ)) begin
      bad++; $display("FAIL alu_fetch got=%b want=%b", outs(), IRL | MREQ);
    end
    tick();
    total++;
    if (outs() !== 11'b0 || pc_disp !== 8'h12) begin
      bad++; $display("FAIL alu_decode got=%b/%h want=%b/12", outs(), pc_disp, 11'b0);
    end
    tick();
    total++;
    if (outs() !== (PCEN | RFWE | FWE)) begin
      bad++; $display("FAIL alu_exec got=%b want=%b", outs(), PCEN | RFWE | FWE);
    end
    tick();
  endtask

  task automatic test_exec_table();
    vec_t v[17];
    v[0]  = '{16'hC005, 5'b00010, PCEN | BR,        8'h05};  // EQ, Z=1
    v[1]  = '{16'hC005, 5'b00000, PCEN,             8'h05};  // EQ, Z=0
    v[2]  = '{16'hC1F0, 5'b00000, PCEN | BR,        8'hF0};  // NE, Z=0
    v[3]  = '{16'hCA10, 5'b00000, PCEN | BR,        8'h10};  // LO, L=0 Z=0
    v[4]  = '{16'hCA10, 5'b01000, PCEN,             8'h10};  // LO, L=1
    v[5]  = '{16'hCD22, 5'b00001, PCEN | BR,        8'h22};  // GE, N=1
    v[6]  = '{16'hCC22, 5'b00001, PCEN,             8'h22};  // LT, N=1
    v[7]  = '{16'hC820, 5'b00100, PCEN | BR,        8'h20};  // FS, F=1
    v[8]  = '{16'hC220, 5'b10000, PCEN | BR,        8'h20};  // CS, C=1
    v[9]  = '{16'hCF20, 5'b11111, PCEN,             8'h20};  // never
    v[10] = '{16'h4EC3, 5'b00000, PCEN | JMP,       8'hC3};  // Jcond UC
    v[11] = '{16'h4FC3, 5'b11111, PCEN,             8'hC3};  // Jcond never
    v[12] = '{16'h40C3, 5'b00010, PCEN | JMP,       8'hC3};  // Jcond EQ, Z=1
    v[13] = '{16'hB512, 5'b00000, PCEN | FWE,       8'h12};  // CMPI
    v[14] = '{16'h05B2, 5'b00000, PCEN | FWE,       8'hB2};  // CMP register form
    v[15] = '{16'h4A52, 5'b00000, PCEN,             8'h52};  // undefined ext -> NOP
    v[16] = '{16'h5103, 5'b00000, PCEN | RFWE | FWE, 8'h03}; // ADDI
    for (int i = 0; i < 17; i++) begin
      instr = v[i].ins; flags = v[i].fl; mem_ready = 1'b1;
      #1;
      total++;
      if (outs() !== (IRL | MREQ)) begin
        bad++; $display("FAIL tbl_fetch[%0d] got=%b want=%b", i, outs(), IRL | MREQ);
      end
      tick();
      total++;
      if (outs() !== 11'b0 || pc_disp !== v[i].disp) begin
        bad++;
        $display("FAIL tbl_decode[%0d] got=%b/%h want=%b/%h", i, outs(), pc_disp, 11'b0,
                 v[i].disp);
      end
      tick();
      total++;
      if (outs() !== v[i].ex || pc_disp !== v[i].disp) begin
        bad++;
        $display("FAIL tbl_exec[%0d] got=%b/%h want=%b/%h", i, outs(), pc_disp, v[i].ex,
                 v[i].disp);
      end
      tick();
    end
    flags = 5'b0;
  endtask

  task automatic test_fetch_wait_load();
    instr = 16'h4102; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (outs() !== MREQ) begin
        bad++; $display("FAIL fetch_wait[%0d] got=%b want=%b", i, outs(), MREQ);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (outs() !== (IRL | MREQ)) begin
      bad++; $display("FAIL load_fetch got=%b want=%b", outs(), IRL | MREQ);
    end
    tick();
    mem_ready = 1'b0;
    #1;
    total++;
    if (outs() !== 11'b0) begin
      bad++; $display("FAIL load_decode got=%b want=%b", outs(), 11'b0);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (outs() !== (ASEL | MREQ)) begin
        bad++; $display("FAIL load_wait[%0d] got=%b want=%b", i, outs(), ASEL | MREQ);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (outs() !== (PCEN | RFWE | RSRC | ASEL | MREQ)) begin
      bad++;
      $display("FAIL load_done got=%b want=%b", outs(), PCEN | RFWE | RSRC | ASEL | MREQ);
    end
    tick();
  endtask

  task automatic test_stor();
    instr = 16'h4142; mem_ready = 1'b1;
    tick();  // fetch -> decode
    tick();  // decode -> mem
    total++;
    if (outs() !== (PCEN | ASEL | MREQ | MWE)) begin
      bad++; $display("FAIL stor_mem got=%b want=%b", outs(), PCEN | ASEL | MREQ | MWE);
    end
    tick();
  endtask

  task automatic test_stor_reset();
    instr = 16'h4142; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    total++;
    if (outs() !== (ASEL | MREQ | MWE)) begin
      bad++; $display("FAIL stor_rst_mem got=%b want=%b", outs(), ASEL | MREQ | MWE);
    end
    rst = 1'b1;
    #1;
    total++;
    if (outs() !== 11'b0) begin
      bad++; $display("FAIL stor_rst_cycle got=%b want=%b", outs(), 11'b0);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (outs() !== MREQ || pc_disp !== 8'h00) begin
      bad++; $display("FAIL stor_rst_after got=%b/%h want=%b/00", outs(), pc_disp, MREQ);
    end
    tick();
    total++;
    if (outs() !== MREQ) begin
      bad++; $display("FAIL stor_rst_hold got=%b want=%b", outs(), MREQ);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_zero_word();
    instr = 16'h0000; mem_ready = 1'b1;
    tick();
    tick();
`ifdef CPU_CTRL_HALT_EN
    total++;
    if (outs() !== 11'b0) begin
      bad++; $display("FAIL halt_exec got=%b want=%b", outs(), 11'b0);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (outs() !== HALT) begin
        bad++; $display("FAIL halt_hold[%0d] got=%b want=%b", i, outs(), HALT);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (outs() !== (IRL | MREQ)) begin
      bad++; $display("FAIL halt_cleared got=%b want=%b", outs(), IRL | MREQ);
    end
`else
    total++;
    if (outs() !== PCEN) begin
      bad++; $display("FAIL nop_exec got=%b want=%b", outs(), PCEN);
    end
    tick();
    instr = 16'h0512;
    #1;
    total++;
    if (outs() !== (IRL | MREQ)) begin
      bad++; $display("FAIL nop_next_fetch got=%b want=%b", outs(), IRL | MREQ);
    end
`endif
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; instr = 16'h0; flags = 5'b0; mem_ready = 1'b0;
    test_reset();
    test_alu();
    test_exec_table();
    test_fetch_wait_load();
    test_stor();
    test_alu();  // back to back after a memory instruction
    test_stor_reset();
    test_zero_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
